// File: rtl/echo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : echo_pkg
// Description : Shared definitions for the Echo indication pipe. Both the
//               transmit (output) and receive (input) blocks import this
//               package so the 96-bit message layout is defined once.
//               Layout: [31:0] tag, [63:32] meth, [95:64] v.
// Revision    : 1.0 - initial release
// ============================================================================
package echo_pkg;

  localparam int          ECHO_MSG_W = 96;
  localparam logic [31:0] TAG_HEARD  = 32'd1;

  localparam int TAG_LSB  = 0;
  localparam int METH_LSB = 32;
  localparam int V_LSB    = 64;

  // Packed MSB-first, so the last member lands at bit 0.
  typedef struct packed {
    logic [31:0] v;     // [95:64]
    logic [31:0] meth;  // [63:32]
    logic [31:0] tag;   // [31:0]
  } echo_msg_t;

  function automatic echo_msg_t pack_heard(
    input logic [31:0] tag,
    input logic [31:0] meth,
    input logic [31:0] v
  );
    echo_msg_t msg;
    msg.tag  = tag;
    msg.meth = meth;
    msg.v    = v;
    return msg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/echo_msg_fifo.sv
`default_nettype none
// ============================================================================
// Module      : echo_msg_fifo
// Description : Small circular-buffer FIFO for Echo pipe messages. No
//               bypass: an entry written in cycle N is visible at the head
//               in cycle N+1. When full, enq__RDY stays low even if a deq
//               fires in the same cycle.
// Ports       : CLK, nRST      - clock, asynchronous active-low reset
//               enq__ENA/enq_v - write strobe and data
//               enq__RDY       - not full
//               deq__ENA       - pop strobe (ignored when empty)
//               first          - head entry, combinational
//               deq__RDY       - not empty
// Revision    : 1.0 - initial release
// ============================================================================
module echo_msg_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             enq__ENA,
  input  logic [WIDTH-1:0] enq_v,
  output logic             enq__RDY,
  input  logic             deq__ENA,
  output logic [WIDTH-1:0] first,
  output logic             deq__RDY
);

  localparam int               c_PTR_W = $clog2(DEPTH);
  localparam int               c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic w_enq;
  logic w_deq;

  assign enq__RDY = (r_count != c_FULL);
  assign deq__RDY = (r_count != '0);
  assign w_enq    = enq__ENA & enq__RDY;
  assign w_deq    = deq__ENA & deq__RDY;
  assign first    = r_mem[r_rd_ptr];

  // Storage is not reset; stale entries are unreachable once count is 0.
  always_ff @(posedge CLK) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= enq_v;
    end
  end

  // Pointers are log2(DEPTH) wide, so wrap happens by overflow.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/echo_indication_output.sv
`default_nettype none
// ============================================================================
// Module      : echo_indication_output
// Description : Transmit side of the Echo indication pipe. Packs heard()
//               calls into 96-bit tagged messages, buffers them in a FIFO
//               and drains them to the downstream pipe under the scheduler's
//               output_rule enable. Counts delivered messages.
// Ports       : CLK, nRST                  - clock, async active-low reset
//               heard__ENA/meth/v          - heard() call
//               heard__RDY                 - heard() may be called
//               pipe_enq__ENA/pipe_enq_v   - message to downstream pipe
//               pipe_enq__RDY              - downstream can accept
//               rule_enable/rule_ready     - output_rule enable / guard
//               sent_count                 - messages delivered (mod 2^32)
// Revision    : 1.0 - initial release
// ============================================================================
module echo_indication_output
  import echo_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] TAG_HEARD = echo_pkg::TAG_HEARD
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  heard__ENA,
  input  logic [31:0]           heard_meth,
  input  logic [31:0]           heard_v,
  output logic                  heard__RDY,
  output logic                  pipe_enq__ENA,
  output logic [ECHO_MSG_W-1:0] pipe_enq_v,
  input  logic                  pipe_enq__RDY,
  input  logic                  rule_enable,
  output logic                  rule_ready,
  output logic [31:0]           sent_count
);

  echo_msg_t   w_msg;
  logic [ECHO_MSG_W-1:0] w_head;
  logic        w_not_empty;
  logic        w_deq;
  logic [31:0] r_sent_count;

  // The tag is packed here and stored with the entry, so the head is sent
  // exactly as it was enqueued.
  assign w_msg = pack_heard(TAG_HEARD, heard_meth, heard_v);

  echo_msg_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ECHO_MSG_W)
  ) u_fifo (
    .CLK      (CLK),
    .nRST     (nRST),
    .enq__ENA (heard__ENA),
    .enq_v    (w_msg),
    .enq__RDY (heard__RDY),
    .deq__ENA (w_deq),
    .first    (w_head),
    .deq__RDY (w_not_empty)
  );

  assign rule_ready    = w_not_empty & pipe_enq__RDY;
  assign w_deq         = rule_enable & rule_ready;
  assign pipe_enq__ENA = w_deq;
  assign pipe_enq_v    = w_head;
  assign sent_count    = r_sent_count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_sent_count <= '0;
    end else if (w_deq) begin
      r_sent_count <= r_sent_count + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_echo_indication_output.sv
`default_nettype none
// ============================================================================
// Module      : tb_echo_indication_output
// Description : Self-checking bench for echo_indication_output. Accepted
//               heard() calls push their expected message into a queue; a
//               monitor pops and compares on every pipe_enq__ENA.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_echo_indication_output;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        heard_ena;
  logic [31:0] heard_meth;
  logic [31:0] heard_v;
  logic        heard_rdy;
  logic        pipe_ena;
  logic [95:0] pipe_v;
  logic        pipe_rdy;
  logic        rule_enable;
  logic        rule_ready;
  logic [31:0] sent_count;

  int          checks = 0;
  int          errors = 0;
  int          enq_seen = 0;
  logic [31:0] exp_sent = 32'd0;
  logic [95:0] sb_q[$];
  logic [95:0] mon_exp;

  always #5 CLK = ~CLK;

  echo_indication_output #(
    .DEPTH     (DEPTH),
    .TAG_HEARD (32'd1)
  ) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .heard__ENA    (heard_ena),
    .heard_meth    (heard_meth),
    .heard_v       (heard_v),
    .heard__RDY    (heard_rdy),
    .pipe_enq__ENA (pipe_ena),
    .pipe_enq_v    (pipe_v),
    .pipe_enq__RDY (pipe_rdy),
    .rule_enable   (rule_enable),
    .rule_ready    (rule_ready),
    .sent_count    (sent_count)
  );

  function automatic logic [95:0] msg(input logic [31:0] meth, input logic [31:0] v);
    return {v, meth, 32'd1};
  endfunction

  // Scoreboard consumer: every delivered message must be the oldest expected one.
  always @(negedge CLK) begin
    if (nRST === 1'b1 && pipe_ena === 1'b1) begin
      enq_seen++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL monitor_unexpected: got %h, required no message", pipe_v);
      end else begin
        mon_exp = sb_q.pop_front();
        if (pipe_v !== mon_exp) begin
          errors++;
          $display("FAIL monitor_data: got %h, required %h", pipe_v, mon_exp);
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d messages outstanding after %0d cycles, required 0", name, sb_q.size(), n);
      sb_q.delete();
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; heard_ena = 1'b0; heard_meth = '0; heard_v = '0;
    pipe_rdy = 1'b1; rule_enable = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++; if (heard_rdy !== 1'b1) begin errors++; $display("FAIL reset_heard_rdy: got %b, required 1", heard_rdy); end
    checks++; if (pipe_ena !== 1'b0) begin errors++; $display("FAIL reset_pipe_ena: got %b, required 0", pipe_ena); end
    checks++; if (rule_ready !== 1'b0) begin errors++; $display("FAIL reset_rule_ready: got %b, required 0", rule_ready); end
    checks++; if (sent_count !== 32'd0) begin errors++; $display("FAIL reset_sent_count: got %h, required 0", sent_count); end
    @(posedge CLK); #2;
    nRST = 1'b1;
    exp_sent = 32'd0;
    @(posedge CLK); #1;
  endtask

  task automatic test_single();
    heard_ena = 1'b1; heard_meth = 32'h5; heard_v = 32'hDEADBEEF;
    sb_q.push_back(msg(32'h5, 32'hDEADBEEF));
    @(negedge CLK);
    checks++; if (pipe_ena !== 1'b0) begin errors++; $display("FAIL single_no_bypass: ena got %b, required 0", pipe_ena); end
    @(posedge CLK); #1;
    heard_ena = 1'b0;
    @(negedge CLK);
    checks++; if (pipe_ena !== 1'b1) begin errors++; $display("FAIL single_ena: got %b, required 1", pipe_ena); end
    checks++; if (pipe_v !== 96'hDEADBEEF_00000005_00000001) begin errors++; $display("FAIL single_data: got %h, required deadbeef0000000500000001", pipe_v); end
    @(posedge CLK); #1;
    exp_sent = exp_sent + 32'd1;
    @(negedge CLK);
    checks++; if (pipe_ena !== 1'b0) begin errors++; $display("FAIL single_one_pulse: ena got %b, required 0", pipe_ena); end
    checks++; if (sent_count !== 32'd1) begin errors++; $display("FAIL single_sent_count: got %0d, required 1", sent_count); end
    @(posedge CLK); #1;
  endtask

  task automatic test_backpressure();
    pipe_rdy = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      heard_ena = 1'b1; heard_meth = 32'h100 + 32'(i); heard_v = $urandom;
      @(negedge CLK);
      checks++; if (heard_rdy !== (i < DEPTH)) begin errors++; $display("FAIL bp_heard_rdy[%0d]: got %b, required %b", i, heard_rdy, (i < DEPTH)); end
      checks++; if (rule_ready !== 1'b0) begin errors++; $display("FAIL bp_rule_ready[%0d]: got %b, required 0", i, rule_ready); end
      if (i < DEPTH) sb_q.push_back(msg(heard_meth, heard_v));
      @(posedge CLK); #1;
    end
    // Fifth call is still held; open the pipe.
    pipe_rdy = 1'b1;
    @(negedge CLK);
    checks++; if (heard_rdy !== 1'b0) begin errors++; $display("FAIL bp_full_rdy: got %b, required 0", heard_rdy); end
    checks++; if (pipe_ena !== 1'b1) begin errors++; $display("FAIL bp_release_ena: got %b, required 1", pipe_ena); end
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++; if (heard_rdy !== 1'b1) begin errors++; $display("FAIL bp_fifth_rdy: got %b, required 1", heard_rdy); end
    sb_q.push_back(msg(heard_meth, heard_v));
    @(posedge CLK); #1;
    heard_ena = 1'b0;
    wait_drain("bp");
    exp_sent = exp_sent + 32'(DEPTH + 1);
    checks++; if (sent_count !== exp_sent) begin errors++; $display("FAIL bp_sent_count: got %0d, required %0d", sent_count, exp_sent); end
  endtask

  task automatic test_full_simul_deq();
    pipe_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      heard_ena = 1'b1; heard_meth = 32'h200 + 32'(i); heard_v = $urandom;
      sb_q.push_back(msg(heard_meth, heard_v));
      @(posedge CLK); #1;
    end
    heard_ena = 1'b1; heard_meth = 32'hBAD; heard_v = 32'hBAD0BAD0; pipe_rdy = 1'b1;
    @(negedge CLK);
    checks++; if (heard_rdy !== 1'b0) begin errors++; $display("FAIL full_deq_rdy: got %b, required 0", heard_rdy); end
    checks++; if (pipe_ena !== 1'b1) begin errors++; $display("FAIL full_deq_ena: got %b, required 1", pipe_ena); end
    @(posedge CLK); #1;
    heard_ena = 1'b0; pipe_rdy = 1'b0;
    @(negedge CLK);
    checks++; if (heard_rdy !== 1'b1) begin errors++; $display("FAIL full_after_deq_rdy: got %b, required 1", heard_rdy); end
    @(posedge CLK); #1;
    pipe_rdy = 1'b1;
    wait_drain("full_deq");
    exp_sent = exp_sent + 32'(DEPTH);
    checks++; if (sent_count !== exp_sent) begin errors++; $display("FAIL full_deq_sent_count: got %0d, required %0d", sent_count, exp_sent); end
  endtask

  task automatic test_reset_midstream();
    int seen_before;
    pipe_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      heard_ena = 1'b1; heard_meth = 32'h300 + 32'(i); heard_v = $urandom;
      @(posedge CLK); #1;
    end
    heard_ena = 1'b0;
    pipe_rdy = 1'b1;
    #1;
    checks++; if (pipe_ena !== 1'b1) begin errors++; $display("FAIL mid_ena_before: got %b, required 1", pipe_ena); end
    #1;
    nRST = 1'b0;
    #1;
    checks++; if (pipe_ena !== 1'b0) begin errors++; $display("FAIL mid_ena_async: got %b, required 0", pipe_ena); end
    checks++; if (heard_rdy !== 1'b1) begin errors++; $display("FAIL mid_heard_rdy: got %b, required 1", heard_rdy); end
    checks++; if (sent_count !== 32'd0) begin errors++; $display("FAIL mid_sent_async: got %0d, required 0", sent_count); end
    exp_sent = 32'd0;
    @(posedge CLK); @(posedge CLK); #2;
    nRST = 1'b1;
    seen_before = enq_seen;
    repeat (10) @(posedge CLK);
    #1;
    checks++; if (enq_seen != seen_before) begin errors++; $display("FAIL mid_stale: got %0d messages, required 0", enq_seen - seen_before); end
    checks++; if (sent_count !== 32'd0) begin errors++; $display("FAIL mid_sent_count: got %0d, required 0", sent_count); end
  endtask

  task automatic test_random();
    int  m_count = 0;
    logic exp_rdy, exp_rr, exp_ena;
    for (int c = 0; c < 300; c++) begin
      heard_ena   = ($urandom_range(0, 9) < 6);
      heard_meth  = $urandom;
      heard_v     = $urandom;
      pipe_rdy    = ($urandom_range(0, 9) < 5);
      rule_enable = ($urandom_range(0, 9) < 8);
      #1;
      exp_rdy = (m_count != DEPTH);
      exp_rr  = (m_count != 0) && pipe_rdy;
      exp_ena = exp_rr && rule_enable;
      checks++; if (heard_rdy !== exp_rdy) begin errors++; $display("FAIL rand_heard_rdy[%0d]: got %b, required %b", c, heard_rdy, exp_rdy); end
      checks++; if (rule_ready !== exp_rr) begin errors++; $display("FAIL rand_rule_ready[%0d]: got %b, required %b", c, rule_ready, exp_rr); end
      checks++; if (pipe_ena !== exp_ena) begin errors++; $display("FAIL rand_pipe_ena[%0d]: got %b, required %b", c, pipe_ena, exp_ena); end
      if (heard_ena && exp_rdy) begin
        sb_q.push_back(msg(heard_meth, heard_v));
        m_count++;
      end
      if (exp_ena) begin
        m_count--;
        exp_sent = exp_sent + 32'd1;
      end
      @(posedge CLK); #1;
    end
    heard_ena = 1'b0; pipe_rdy = 1'b1; rule_enable = 1'b1;
    exp_sent = exp_sent + 32'(m_count);
    wait_drain("rand");
    checks++; if (sent_count !== exp_sent) begin errors++; $display("FAIL rand_sent_count: got %0d, required %0d", sent_count, exp_sent); end
  endtask

  task automatic test_wrap();
    force dut.r_sent_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_sent_count;
    heard_ena = 1'b1; heard_meth = 32'h7; heard_v = 32'h77;
    sb_q.push_back(msg(32'h7, 32'h77));
    @(posedge CLK); #1;
    heard_ena = 1'b0;
    wait_drain("wrap");
    checks++; if (sent_count !== 32'd0) begin errors++; $display("FAIL wrap_sent_count: got %h, required 00000000", sent_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_full_simul_deq();
    test_reset_midstream();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
